// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, instruction
// classes, opcode/funct constants and datapath select codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {C_ILL, C_R, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J} cls_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;
  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BR     = 2'b01;
  localparam logic [1:0] PC_JMP    = 2'b10;
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_EXT    = 2'b10;

  // Extender mode a class needs in EXEC; WB keeps the same value so lui/lw data stays stable.
  function automatic logic [1:0] ext_of(cls_t c);
    case (c)
      C_LUI:      return EXT_UPPER;
      C_LW, C_SW: return EXT_SIGN;
      default:    return EXT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> class, subtract flag, illegal.
module mc_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [5:0]       funct,
  output cls_t             cls,
  output logic             sub,
  output logic             illegal
);

  always_comb begin
    cls = C_ILL;
    sub = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADDU: cls = C_R;
          FN_SUBU: begin cls = C_R; sub = 1'b1; end
          default: cls = C_ILL;
        endcase
      end
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_J:    cls = C_J;
      default: cls = C_ILL;
    endcase
    illegal = (cls == C_ILL);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb over a shared ALU and one memory port.
// Outputs are Moore-decoded from state and latched class; mem_ready/alu_zero are the only Mealy terms.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ab_we,
  output logic [1:0]       ext_op,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             rf_we,
  output logic             reg_dst,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt
);

  state_t           state_q, state_d;
  cls_t             cls_q, dec_cls;
  logic             sub_q, dec_sub, dec_ill;
  logic             ill_q;
  logic [CNT_W-1:0] cnt_q;

  mc_decode #(.OPC_W(OPC_W)) u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (dec_cls),
    .sub     (dec_sub),
    .illegal (dec_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cls_q   <= C_ILL;
      sub_q   <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q <= dec_cls;
        sub_q <= dec_sub;
        if (dec_ill) ill_q <= 1'b1;
      end
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_INC;
    ab_we     = 1'b0;
    ext_op    = EXT_ZERO;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_we   = 1'b1;
        ext_op  = EXT_SIGN;
        state_d = dec_ill ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        ext_op = ext_of(cls_q);
        case (cls_q)
          C_R: begin
            alu_op  = sub_q ? ALU_SUB : ALU_ADD;
            state_d = S_WB;
          end
          C_ORI: begin
            alu_src_b = 1'b1;
            alu_op    = ALU_OR;
            state_d   = S_WB;
          end
          C_LUI: state_d = S_WB;
          C_LW, C_SW: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          C_BEQ: begin
            alu_op  = ALU_SUB;
            pc_src  = PC_BR;
            pc_we   = alu_zero;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_J: begin
            pc_src  = PC_JMP;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (cls_q == C_SW);
        if (mem_ready) begin
          if (cls_q == C_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        reg_dst = (cls_q == C_R);
        ext_op  = ext_of(cls_q);
        wb_sel  = (cls_q == C_LW) ? WB_MEM : (cls_q == C_LUI) ? WB_EXT : WB_ALU;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign illegal     = ill_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus pushes hand-built expected output words per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_mc_ctrl;

  localparam int CNT_W = 4;

  // Expected-word field bits (hand-assembled per cycle).
  localparam logic [18:0] RET      = 19'd1 << 0;
  localparam logic [18:0] ILL      = 19'd1 << 1;
  localparam logic [18:0] WB_MEM   = 19'd1 << 2;
  localparam logic [18:0] WB_EXT   = 19'd2 << 2;
  localparam logic [18:0] RDST     = 19'd1 << 4;
  localparam logic [18:0] RFWE     = 19'd1 << 5;
  localparam logic [18:0] ALU_SUB  = 19'd1 << 6;
  localparam logic [18:0] ALU_OR   = 19'd2 << 6;
  localparam logic [18:0] SRCB     = 19'd1 << 8;
  localparam logic [18:0] EXT_SIGN = 19'd1 << 9;
  localparam logic [18:0] EXT_UP   = 19'd2 << 9;
  localparam logic [18:0] ABWE     = 19'd1 << 11;
  localparam logic [18:0] PC_BR    = 19'd1 << 12;
  localparam logic [18:0] PC_J     = 19'd2 << 12;
  localparam logic [18:0] PCWE     = 19'd1 << 14;
  localparam logic [18:0] IRWE     = 19'd1 << 15;
  localparam logic [18:0] MSEL     = 19'd1 << 16;
  localparam logic [18:0] MWE      = 19'd1 << 17;
  localparam logic [18:0] MREQ     = 19'd1 << 18;

  localparam logic [5:0] O_R = 6'b000000, O_ORI = 6'b001101, O_LUI = 6'b001111;
  localparam logic [5:0] O_LW = 6'b100011, O_SW = 6'b101011, O_BEQ = 6'b000100;
  localparam logic [5:0] O_J = 6'b000010, F_ADDU = 6'b100001, F_SUBU = 6'b100011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic alu_zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, mem_sel, ir_we, pc_we, ab_we, alu_src_b, rf_we, reg_dst, illegal, retire;
  logic [1:0] pc_src, ext_op, alu_op, wb_sel;
  logic [CNT_W-1:0] retired_cnt;

  always #5 clk = ~clk;

  mc_ctrl #(.OPC_W(6), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .ab_we(ab_we), .ext_op(ext_op),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .rf_we(rf_we), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .illegal(illegal), .retire(retire), .retired_cnt(retired_cnt)
  );

  logic [18:0] obs;
  assign obs = {mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, ab_we, ext_op,
                alu_src_b, alu_op, rf_we, reg_dst, wb_sel, illegal, retire};

  typedef struct {
    logic [18:0]      o;
    logic [CNT_W-1:0] cnt;
    string            nm;
  } rec_t;

  rec_t             q[$];
  rec_t             mr;
  int               tests = 0, fails = 0;
  logic [18:0]      ill_e = '0;
  logic [CNT_W-1:0] cnt_e = '0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mr = q.pop_front();
      tests++;
      if (obs !== mr.o) begin
        fails++;
        $display("FAIL %s: outputs got %b want %b", mr.nm, obs, mr.o);
      end
      tests++;
      if (retired_cnt !== mr.cnt) begin
        fails++;
        $display("FAIL %s_cnt: retired_cnt got %0d want %0d", mr.nm, retired_cnt, mr.cnt);
      end
    end
  end

  task automatic push(input logic [18:0] e, input string nm);
    rec_t r;
    r.o = e | ill_e; r.cnt = cnt_e; r.nm = nm;
    q.push_back(r);
    if (e[0]) cnt_e = cnt_e + 1'b1;
  endtask

  task automatic step(input logic [5:0] opc, input logic [5:0] fn, input logic rdy,
                      input logic z, input logic [18:0] e, input string nm);
    @(posedge clk); #1;
    opcode = opc; funct = fn; mem_ready = rdy; alu_zero = z;
    push(e, nm);
  endtask

  // Fetch (with optional wait cycles) plus decode; mem_ready is held high in decode to show it is ignored.
  task automatic fetch(input logic [5:0] opc, input logic [5:0] fn, input int waits);
    for (int i = 0; i < waits; i++) step(opc, fn, 1'b0, 1'b0, MREQ, "fetch_wait");
    step(opc, fn, 1'b1, 1'b0, MREQ | IRWE | PCWE, "fetch");
    step(opc, fn, 1'b1, 1'b0, ABWE | EXT_SIGN, "decode");
  endtask

  task automatic do_addu();
    fetch(O_R, F_ADDU, 0);
    step(O_R, F_ADDU, 1'b1, 1'b0, '0, "addu_ex");
    step(O_R, F_ADDU, 1'b1, 1'b0, RFWE | RDST | RET, "addu_wb");
  endtask

  task automatic do_j();
    fetch(O_J, 6'd0, 0);
    step(O_J, 6'd0, 1'b1, 1'b1, PC_J | PCWE | RET, "j_ex");
  endtask

  initial begin
    @(posedge clk); #1;
    push('0, "reset");
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1;
    push('0, "init");

    do_addu();
    fetch(O_R, F_SUBU, 0);
    step(O_R, F_SUBU, 1'b1, 1'b0, ALU_SUB, "subu_ex");
    step(O_R, F_SUBU, 1'b1, 1'b0, RFWE | RDST | RET, "subu_wb");
    fetch(O_LUI, 6'd0, 0);
    step(O_LUI, 6'd0, 1'b1, 1'b0, EXT_UP, "lui_ex");
    step(O_LUI, 6'd0, 1'b1, 1'b0, RFWE | WB_EXT | EXT_UP | RET, "lui_wb");
    fetch(O_ORI, 6'd0, 0);
    step(O_ORI, 6'd0, 1'b1, 1'b0, SRCB | ALU_OR, "ori_ex");
    step(O_ORI, 6'd0, 1'b1, 1'b0, RFWE | RET, "ori_wb");
    fetch(O_LW, 6'd0, 0);
    step(O_LW, 6'd0, 1'b1, 1'b0, EXT_SIGN | SRCB, "lw_ex");
    step(O_LW, 6'd0, 1'b1, 1'b0, MREQ | MSEL, "lw_mem");
    step(O_LW, 6'd0, 1'b1, 1'b0, RFWE | WB_MEM | EXT_SIGN | RET, "lw_wb");
    // lw with three wait cycles in MEM: eight cycles total
    fetch(O_LW, 6'd0, 0);
    step(O_LW, 6'd0, 1'b0, 1'b0, EXT_SIGN | SRCB, "lw2_ex");
    for (int i = 0; i < 3; i++) step(O_LW, 6'd0, 1'b0, 1'b0, MREQ | MSEL, "lw2_mem_wait");
    step(O_LW, 6'd0, 1'b1, 1'b0, MREQ | MSEL, "lw2_mem");
    step(O_LW, 6'd0, 1'b1, 1'b0, RFWE | WB_MEM | EXT_SIGN | RET, "lw2_wb");
    fetch(O_SW, 6'd0, 1);
    step(O_SW, 6'd0, 1'b0, 1'b0, EXT_SIGN | SRCB, "sw_ex");
    for (int i = 0; i < 2; i++) step(O_SW, 6'd0, 1'b0, 1'b0, MREQ | MSEL | MWE, "sw_mem_wait");
    step(O_SW, 6'd0, 1'b1, 1'b0, MREQ | MSEL | MWE | RET, "sw_mem");
    fetch(O_BEQ, 6'd0, 0);
    step(O_BEQ, 6'd0, 1'b1, 1'b1, ALU_SUB | PC_BR | PCWE | RET, "beq_taken");
    fetch(O_BEQ, 6'd0, 0);
    step(O_BEQ, 6'd0, 1'b1, 1'b0, ALU_SUB | PC_BR | RET, "beq_not_taken");
    do_j();

    // undecodable opcode: decode goes straight back to fetch, flag then stays set
    fetch(6'b111111, 6'd0, 0);
    ill_e = ILL;
    do_j();

    // run jumps until the 4-bit counter wraps through all-ones to 0
    for (int k = 0; k < 16 && cnt_e != '0; k++) do_j();
    do_addu();

    // reset during a fetch wait: mem_req drops before the next edge, count clears
    step(O_R, F_ADDU, 1'b0, 1'b0, MREQ, "fetch_wait_pre_rst");
    @(posedge clk); #1;
    rst_n = 1'b0;
    ill_e = '0; cnt_e = '0;
    push('0, "rst_mid_fetch");
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1;
    push('0, "init2");
    do_addu();
    step(O_R, F_ADDU, 1'b0, 1'b0, MREQ, "final_fetch");

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: pending got %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, pending %0d want 0", q.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS-subset CPU datapath. Sequences fetch, decode, execute, memory and write-back over a shared ALU, the immediate extender and a single memory port with a ready handshake. Drives the extender mode select for zero, sign and upper (LUI) extension. Also flags illegal instructions and counts retired instructions.

## Interface
- `OPC_W`, 6: opcode width.
- `CNT_W`, 32: retired-instruction counter width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `alu_zero` in 1: ALU zero flag, sampled in EXEC.
- `mem_ready` in 1: memory port completion, sampled while `mem_req`=1.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: store when 1.
- `mem_sel` out 1: 0 = address from PC, 1 = address from ALU out.
- `ir_we` out 1: IR load enable.
- `pc_we` out 1: PC load enable.
- `pc_src` out 2: 00 PC+4, 01 branch target, 10 jump target.
- `ab_we` out 1: load A/B operand registers.
- `ext_op` out 2: 00 zero-ext, 01 sign-ext, 10 upper ({imm16,16'b0}).
- `alu_src_b` out 1: 0 = B register, 1 = extended immediate.
- `alu_op` out 2: 00 add, 01 sub, 10 or.
- `rf_we` out 1: register-file write enable.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `wb_sel` out 2: 00 ALU out, 01 memory data, 10 extender output.
- `illegal` out 1: sticky, set on undecodable instruction.
- `retire` out 1: one-cycle pulse per completed instruction.
- `retired_cnt` out CNT_W: count of retired instructions.

## Operation
- States: INIT, FETCH, DECODE, EXEC, MEM, WB.
- Outputs are Moore-decoded from state and the latched instruction class. The only Mealy terms are `mem_ready` and `alu_zero`.
- All unlisted outputs are 0 in every state.
- Supported instructions:
  - addu (R/100001), subu (R/100011)
  - ori (001101), lui (001111)
  - lw (100011), sw (101011)
  - beq (000100), j (000010)
- INIT: all outputs 0; next state is FETCH.
- FETCH:
  - Drive `mem_req`=1, `mem_sel`=0 and hold them until `mem_ready`.
  - On `mem_ready`: `ir_we`=1 and `pc_we`=1 with `pc_src`=00, then go to DECODE.
- DECODE:
  - Drive `ab_we`=1 and `ext_op`=01 (branch offset).
  - Latch the decoded class.
  - Illegal opcode or funct: set `illegal`, go to FETCH, no retire.
  - Otherwise go to EXEC.
- EXEC, by class:
  - R-type: `alu_op` from funct, `alu_src_b`=0, go to WB.
  - ori: `ext_op`=00, `alu_src_b`=1, `alu_op`=10, go to WB.
  - lui: `ext_op`=10, go to WB.
  - lw/sw: `ext_op`=01, `alu_src_b`=1, `alu_op`=00, go to MEM.
  - beq: `alu_op`=01, `alu_src_b`=0, `pc_src`=01, `pc_we`=`alu_zero`, retire, go to FETCH.
  - j: `pc_src`=10, `pc_we`=1, retire, go to FETCH.
- MEM:
  - Drive `mem_req`=1, `mem_sel`=1, and `mem_we`=1 for sw. Hold until `mem_ready`.
  - On `mem_ready`: sw retires and goes to FETCH; lw goes to WB.
- WB:
  - `rf_we`=1 for one cycle.
  - `reg_dst`=1 for R-type only.
  - `wb_sel`: 01 for lw, 10 for lui, 00 otherwise.
  - `ext_op` is held at the EXEC value.
  - Retire, go to FETCH.
- `retire` is asserted in the final cycle of each instruction. `retired_cnt` increments on the same edge and wraps from all-ones to 0.

## Timing
- Reset (async assert, sync-released by the system):
  - State INIT, `illegal`=0, `retired_cnt`=0.
  - All other outputs 0.
- First `mem_req` is one cycle after reset deassertion.
- Latency with zero-wait memory (`mem_ready` already high):
  - R/ori/lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/j: 3 cycles.
- Each cycle of `mem_ready`=0 adds exactly one cycle. `mem_req`, `mem_we` and `mem_sel` stay stable while waiting.
- `mem_ready` is ignored when `mem_req`=0.
- Reset mid-access: `mem_req` drops asynchronously. The partial instruction does not retire and the count is cleared.
- `illegal` clears only on reset.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state enum;
  - opcode/funct constants;
  - `ext_op`, `alu_op`, `pc_src`, `wb_sel` encodings;
  - instruction-class enum.
- Sub-module `mc_decode`: combinational opcode/funct → class plus illegal flag.

## Test plan
- Reset, then addu with `mem_ready` tied 1 → FETCH at cycle 1; `rf_we`=1, `reg_dst`=1 at cycle 4; `retired_cnt`=1.
- lui → EXEC and WB show `ext_op`=10; WB shows `wb_sel`=10; ori shows `ext_op`=00; lw shows `ext_op`=01.
- lw with `mem_ready` low for 3 cycles in MEM → `mem_req`/`mem_sel`=1 held for 4 cycles; `rf_we` one cycle later with `wb_sel`=01; total 8 cycles.
- beq with `alu_zero`=1, then with `alu_zero`=0 → `pc_we`=1 with `pc_src`=01, then `pc_we`=0; both retire in 3 cycles.
- Opcode 111111 → `illegal`=1 sticky; no retire; next FETCH follows DECODE.
- `rst_n` low during FETCH wait, and preload `retired_cnt`=all-ones then retire → `mem_req` drops immediately; counter wraps to 0.
